// File: rtl/idex_pipe_reg_pkg.sv
// Shared CPU definitions used by the ID/EX pipeline register:
// default widths, the architectural zero register and bubble field values.
package idex_pipe_reg_pkg;

    localparam int CTRL_W_DEF = 24;
    localparam int BCNT_W_DEF = 16;

    localparam logic [4:0] GPR_ZERO = 5'd0;

    // A bubble targets $zero and claims its result is ready, so downstream
    // forwarding units neither match it nor stall on it.
    localparam logic [4:0] BUBBLE_WB = GPR_ZERO;
    localparam logic       BUBBLE_DV = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } idex_state_t;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_BUBBLE
    } idex_act_t;

endpackage

// File: rtl/idex_pipe_reg_if.sv
// ID-side and EX-side signals of the ID/EX pipeline register.
// The master is the ID stage/core; the slave is the pipeline register.
interface idex_pipe_reg_if
    import idex_pipe_reg_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int BCNT_W = BCNT_W_DEF
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [31:0]       id_opa;
    logic [31:0]       id_opb;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        id_wb;
    logic              id_dv;
    logic              fwd_stall_a;
    logic              fwd_stall_b;
    logic              ex_busy;
    logic              flush;

    logic              id_hold;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_opa;
    logic [31:0]       ex_opb;
    logic [31:0]       ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_wb;
    logic              ex_dv;
    logic [BCNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_pc, id_opa, id_opb, id_imm, id_ctrl, id_wb, id_dv,
               fwd_stall_a, fwd_stall_b, ex_busy, flush,
        input  id_hold, ex_valid, ex_pc, ex_opa, ex_opb, ex_imm, ex_ctrl,
               ex_wb, ex_dv, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_opa, id_opb, id_imm, id_ctrl, id_wb, id_dv,
               fwd_stall_a, fwd_stall_b, ex_busy, flush,
        output id_hold, ex_valid, ex_pc, ex_opa, ex_opb, ex_imm, ex_ctrl,
               ex_wb, ex_dv, bubble_cnt
    );

endinterface

// File: rtl/idex_pipe_reg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [BCNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: latches forwarded operands and decoded control,
// inserts bubbles on load-use stalls and flushes, and counts stall bubbles.
module idex_pipe_reg
    import idex_pipe_reg_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int BCNT_W = BCNT_W_DEF
) (
    input logic            clk,
    input logic            rst_n,
    idex_pipe_reg_if.slave bus
);

    idex_state_t       state_q, state_d;
    idex_act_t         act;
    logic              fstall;
    logic              count_inc;

    logic [31:0]       pc_q, opa_q, opb_q, imm_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [4:0]        wb_q;
    logic              dv_q;
    logic [BCNT_W-1:0] bubble_cnt;

    assign fstall      = bus.id_valid & (bus.fwd_stall_a | bus.fwd_stall_b);
    // Hold is released during flush so IF/ID can load the redirect target.
    assign bus.id_hold = ~bus.flush & (bus.ex_busy | fstall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: flush > ex_busy > forwarding stall > new instruction > idle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_d   = ST_EMPTY;
        act       = ACT_BUBBLE;
        count_inc = 1'b0;
        if (bus.flush) begin
            act = ACT_BUBBLE;
        end else if (bus.ex_busy) begin
            act     = ACT_HOLD;
            state_d = state_q;
        end else if (fstall) begin
            act       = ACT_BUBBLE;
            count_inc = 1'b1;
        end else if (bus.id_valid) begin
            act     = ACT_LOAD;
            state_d = ST_FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            imm_q  <= '0;
            ctrl_q <= '0;
            wb_q   <= BUBBLE_WB;
            dv_q   <= BUBBLE_DV;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            unique case (act)
                ACT_LOAD: begin
                    pc_q   <= bus.id_pc;
                    opa_q  <= bus.id_opa;
                    opb_q  <= bus.id_opb;
                    imm_q  <= bus.id_imm;
                    ctrl_q <= bus.id_ctrl;
                    wb_q   <= bus.id_wb;
                    dv_q   <= bus.id_dv;
                end
                ACT_BUBBLE: begin
                    // Data fields are don't-care in a bubble and simply hold.
                    ctrl_q <= '0;
                    wb_q   <= BUBBLE_WB;
                    dv_q   <= BUBBLE_DV;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.BCNT_W(BCNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (count_inc),
        .cnt   (bubble_cnt)
    );

    assign bus.ex_valid   = (state_q == ST_FULL);
    assign bus.ex_pc      = pc_q;
    assign bus.ex_opa     = opa_q;
    assign bus.ex_opb     = opb_q;
    assign bus.ex_imm     = imm_q;
    assign bus.ex_ctrl    = ctrl_q;
    assign bus.ex_wb      = wb_q;
    assign bus.ex_dv      = dv_q;
    assign bus.bubble_cnt = bubble_cnt;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Self-checking bench for idex_pipe_reg: table-driven vectors with a scoreboard
// queue, plus hand-written reset and counter-saturation sequences.
module tb_idex_pipe_reg;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    idex_pipe_reg_if #(.CTRL_W(24), .BCNT_W(16)) bus ();
    idex_pipe_reg_if #(.CTRL_W(8),  .BCNT_W(2))  sbus ();

    idex_pipe_reg #(.CTRL_W(24), .BCNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    idex_pipe_reg #(.CTRL_W(8), .BCNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    typedef struct {
        logic        v;
        logic [31:0] opa;
        logic [23:0] ctrl;
        logic [4:0]  wb;
        logic        dv;
        logic        sa;
        logic        sb;
        logic        busy;
        logic        fl;
        logic        e_hold;
        logic        e_valid;
        logic [4:0]  e_wb;
        logic        e_dv;
        logic [31:0] e_opa;
        logic [23:0] e_ctrl;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic        valid;
        logic [4:0]  wb;
        logic        dv;
        logic [31:0] opa;
        logic [23:0] ctrl;
        logic [15:0] cnt;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    // Other operand fields are tied to opa so a single expected value covers them.
    function automatic logic [31:0] pc_of(input logic [31:0] a);
        return {a[15:0], 16'h0040};
    endfunction
    function automatic logic [31:0] opb_of(input logic [31:0] a);
        return ~a;
    endfunction
    function automatic logic [31:0] imm_of(input logic [31:0] a);
        return a ^ 32'h0F0F_0F0F;
    endfunction

    function automatic vec_t mk(
        input logic v, input logic [31:0] opa, input logic [23:0] ctrl,
        input logic [4:0] wb, input logic dv, input logic sa, input logic sb,
        input logic busy, input logic fl, input logic e_hold, input logic e_valid,
        input logic [4:0] e_wb, input logic e_dv, input logic [31:0] e_opa,
        input logic [23:0] e_ctrl, input logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.opa = opa; r.ctrl = ctrl; r.wb = wb; r.dv = dv;
        r.sa = sa; r.sb = sb; r.busy = busy; r.fl = fl;
        r.e_hold = e_hold; r.e_valid = e_valid; r.e_wb = e_wb; r.e_dv = e_dv;
        r.e_opa = e_opa; r.e_ctrl = e_ctrl; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid    = t.v;
        bus.id_pc       = pc_of(t.opa);
        bus.id_opa      = t.opa;
        bus.id_opb      = opb_of(t.opa);
        bus.id_imm      = imm_of(t.opa);
        bus.id_ctrl     = t.ctrl;
        bus.id_wb       = t.wb;
        bus.id_dv       = t.dv;
        bus.fwd_stall_a = t.sa;
        bus.fwd_stall_b = t.sb;
        bus.ex_busy     = t.busy;
        bus.flush       = t.fl;
    endtask

    task automatic compare_ex(input exp_t e);
        string p;
        p = $sformatf("v%0d", e.idx);
        check({p, " ex_valid"}, 64'(bus.ex_valid), 64'(e.valid));
        check({p, " ex_wb"},    64'(bus.ex_wb),    64'(e.wb));
        check({p, " ex_dv"},    64'(bus.ex_dv),    64'(e.dv));
        check({p, " ex_opa"},   64'(bus.ex_opa),   64'(e.opa));
        check({p, " ex_pc"},    64'(bus.ex_pc),    64'(pc_of(e.opa)));
        check({p, " ex_opb"},   64'(bus.ex_opb),   64'(opb_of(e.opa)));
        check({p, " ex_imm"},   64'(bus.ex_imm),   64'(imm_of(e.opa)));
        check({p, " ex_ctrl"},  64'(bus.ex_ctrl),  64'(e.ctrl));
        check({p, " bubble_cnt"}, 64'(bus.bubble_cnt), 64'(e.cnt));
    endtask

    initial begin
        //            v  opa           ctrl      wb  dv sa sb bz fl | hold val ewb edv eopa          ectrl     cnt
        vecs.push_back(mk(1, 32'h0000_1234, 24'h11, 8,  1, 0, 0, 0, 0,  0, 1, 8,  1, 32'h0000_1234, 24'h11, 0)); // straight flow
        vecs.push_back(mk(1, 32'h0000_5555, 24'h22, 9,  0, 0, 0, 0, 0,  0, 1, 9,  0, 32'h0000_5555, 24'h22, 0)); // load enters EX
        vecs.push_back(mk(1, 32'h0000_7777, 24'h33, 10, 1, 1, 0, 0, 0,  1, 0, 0,  1, 32'h0000_5555, 24'h00, 1)); // load-use bubble
        vecs.push_back(mk(1, 32'h0000_7777, 24'h33, 10, 1, 0, 0, 0, 0,  0, 1, 10, 1, 32'h0000_7777, 24'h33, 1)); // ID advances
        vecs.push_back(mk(1, 32'h0000_8888, 24'h44, 11, 1, 0, 0, 1, 0,  1, 1, 10, 1, 32'h0000_7777, 24'h33, 1)); // busy 1
        vecs.push_back(mk(1, 32'h0000_8888, 24'h44, 11, 1, 0, 0, 1, 0,  1, 1, 10, 1, 32'h0000_7777, 24'h33, 1)); // busy 2
        vecs.push_back(mk(1, 32'h0000_8888, 24'h44, 11, 1, 0, 0, 1, 0,  1, 1, 10, 1, 32'h0000_7777, 24'h33, 1)); // busy 3
        vecs.push_back(mk(1, 32'h0000_8888, 24'h44, 11, 1, 0, 0, 0, 0,  0, 1, 11, 1, 32'h0000_8888, 24'h44, 1)); // busy released
        vecs.push_back(mk(1, 32'h0000_9999, 24'h66, 12, 1, 0, 1, 1, 1,  0, 0, 0,  1, 32'h0000_8888, 24'h00, 1)); // flush beats all
        vecs.push_back(mk(0, 32'h0000_9999, 24'h66, 12, 1, 0, 0, 0, 0,  0, 0, 0,  1, 32'h0000_8888, 24'h00, 1)); // idle
        vecs.push_back(mk(0, 32'h0000_9999, 24'h66, 12, 1, 1, 0, 0, 0,  0, 0, 0,  1, 32'h0000_8888, 24'h00, 1)); // stall w/o valid
        vecs.push_back(mk(1, 32'h0000_AAAA, 24'h77, 13, 1, 0, 0, 1, 0,  1, 0, 0,  1, 32'h0000_8888, 24'h00, 1)); // busy while EMPTY
        vecs.push_back(mk(1, 32'h0000_AAAA, 24'h77, 13, 1, 0, 1, 0, 0,  1, 0, 0,  1, 32'h0000_8888, 24'h00, 2)); // stall via B
        vecs.push_back(mk(1, 32'h0000_BBBB, 24'h55, 0,  1, 0, 0, 0, 0,  0, 1, 0,  1, 32'h0000_BBBB, 24'h55, 2)); // load, wb=0
        vecs.push_back(mk(1, 32'h0000_CCCC, 24'h88, 14, 1, 1, 0, 1, 0,  1, 1, 0,  1, 32'h0000_BBBB, 24'h55, 2)); // busy beats stall
        vecs.push_back(mk(1, 32'h0000_CCCC, 24'h88, 14, 1, 0, 0, 0, 1,  0, 0, 0,  1, 32'h0000_BBBB, 24'h00, 2)); // flush alone

        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sbus.id_valid = 1'b0; sbus.id_pc = '0; sbus.id_opa = '0; sbus.id_opb = '0;
        sbus.id_imm = '0; sbus.id_ctrl = '0; sbus.id_wb = '0; sbus.id_dv = 1'b1;
        sbus.fwd_stall_a = 1'b0; sbus.fwd_stall_b = 1'b0; sbus.ex_busy = 1'b0; sbus.flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset ex_valid",   64'(bus.ex_valid),   64'd0);
        check("reset ex_wb",      64'(bus.ex_wb),      64'd0);
        check("reset ex_dv",      64'(bus.ex_dv),      64'd1);
        check("reset ex_ctrl",    64'(bus.ex_ctrl),    64'd0);
        check("reset ex_pc",      64'(bus.ex_pc),      64'd0);
        check("reset bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            exp_t e;
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d id_hold", i), 64'(bus.id_hold), 64'(vecs[i].e_hold));
            e.idx = i; e.valid = vecs[i].e_valid; e.wb = vecs[i].e_wb; e.dv = vecs[i].e_dv;
            e.opa = vecs[i].e_opa; e.ctrl = vecs[i].e_ctrl; e.cnt = vecs[i].e_cnt;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("scoreboard empty", 64'd1, 64'd0);
            end else begin
                compare_ex(sb_q.pop_front());
            end
        end
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset in the middle of a cycle with EX full.
        drive(mk(1, 32'h0000_DDDD, 24'h99, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("pre-reset ex_valid", 64'(bus.ex_valid), 64'd1);
        check("pre-reset ex_wb",    64'(bus.ex_wb),    64'd15);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset ex_valid",   64'(bus.ex_valid),   64'd0);
        check("async reset ex_wb",      64'(bus.ex_wb),      64'd0);
        check("async reset ex_dv",      64'(bus.ex_dv),      64'd1);
        check("async reset ex_opa",     64'(bus.ex_opa),     64'd0);
        check("async reset ex_ctrl",    64'(bus.ex_ctrl),    64'd0);
        check("async reset bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
        bus.id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation on the 2-bit counter instance: five stall bubbles.
        sbus.id_valid    = 1'b1;
        sbus.fwd_stall_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat step%0d bubble_cnt", i), 64'(sbus.bubble_cnt),
                  64'((i + 1 > 3) ? 3 : i + 1));
            check($sformatf("sat step%0d id_hold", i), 64'(sbus.id_hold), 64'd1);
            check($sformatf("sat step%0d ex_valid", i), 64'(sbus.ex_valid), 64'd0);
        end
        sbus.id_valid    = 1'b0;
        sbus.fwd_stall_a = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
